// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver.
// Keeps a shadow copy of the digit values and lights one digit per scan slot.
// Each slot starts with a short all-anodes-off interval to stop ghosting
// between neighbouring digits. Leading-zero suppression and hex/BCD decode
// are applied to the digit being shown.
module sevenseg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              a_to_g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PMAX   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PBLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IMAX   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{(AN_ACTIVE_LOW != 0)}};

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shDigits;
  logic [NUM_DIGITS-1:0]   shDp;
  logic [NUM_DIGITS-1:0]   shBlank;
  logic [NUM_DIGITS-1:0]   supp;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    zrun;
  logic [3:0]              liveCode;
  logic                    liveDp, liveBlank, liveSupp;
  logic [3:0]              curCode;
  logic                    curDp, curBlank, curSupp;
  logic [3:0]              showCode;
  logic                    showDp, showBlank, showSupp;
  logic [6:0]              pattern;
  logic [6:0]              segNext;
  logic                    dpNext;
  logic [NUM_DIGITS-1:0]   anNext;

  // Glyph table in active-low abcdefg form; codes 10-15 go dark in BCD mode.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b0000001;
      4'd1:    g = 7'b1001111;
      4'd2:    g = 7'b0010010;
      4'd3:    g = 7'b0000110;
      4'd4:    g = 7'b1001100;
      4'd5:    g = 7'b0100100;
      4'd6:    g = 7'b0100000;
      4'd7:    g = 7'b0001111;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0000100;
      4'd10:   g = 7'b0001000;
      4'd11:   g = 7'b1100000;
      4'd12:   g = 7'b0110001;
      4'd13:   g = 7'b1000010;
      4'd14:   g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (HEX_MODE == 0 && code > 4'd9) g = 7'h7F;
    return g;
  endfunction

  // Slot prescaler and digit index; frame_done marks the first cycle of a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (prescaler == PMAX) begin
        prescaler <= '0;
        if (idx == IMAX) begin
          idx        <= '0;
          frame_done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Shadow copy of the display contents, refreshed only on a load strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shDigits <= '0;
      shDp     <= '0;
      shBlank  <= '0;
    end else if (load) begin
      shDigits <= digits;
      shDp     <= dp_in;
      shBlank  <= blank_in;
    end
  end

  // Leading-zero mask: a digit is dropped when it and everything above it is zero.
  always_comb begin
    zrun = 1'b1;
    supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun    = zrun & (shDigits[4*i +: 4] == 4'd0);
      supp[i] = lz_en & zrun & (i > 0);
    end
  end

  // Pick the shadow entry and anode bit for the digit at the current index.
  always_comb begin
    liveCode  = 4'd0;
    liveDp    = 1'b0;
    liveBlank = 1'b0;
    liveSupp  = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        liveCode  = shDigits[4*i +: 4];
        liveDp    = shDp[i];
        liveBlank = shBlank[i];
        liveSupp  = supp[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // Freeze the digit at slot start so a mid-slot load cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curCode  <= 4'd0;
      curDp    <= 1'b0;
      curBlank <= 1'b0;
      curSupp  <= 1'b0;
    end else if (prescaler == '0) begin
      curCode  <= liveCode;
      curDp    <= liveDp;
      curBlank <= liveBlank;
      curSupp  <= liveSupp;
    end
  end

  // Next output values; on the slot's first cycle the latch is still loading, so use the live entry.
  always_comb begin
    showCode  = (prescaler == '0) ? liveCode  : curCode;
    showDp    = (prescaler == '0) ? liveDp    : curDp;
    showBlank = (prescaler == '0) ? liveBlank : curBlank;
    showSupp  = (prescaler == '0) ? liveSupp  : curSupp;
    pattern   = (showBlank | showSupp) ? 7'h7F : decode(showCode);
    segNext   = SEG_OFF;
    dpNext    = DP_OFF;
    anNext    = AN_OFF;
    if (enable) begin
      segNext = (SEG_ACTIVE_LOW != 0) ? pattern : ~pattern;
      dpNext  = (showDp & ~showBlank) ? ~DP_OFF : DP_OFF;
      if (prescaler >= PBLANK) anNext = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  // Register the pin drive so the board sees glitch-free segment and anode lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_to_g <= SEG_OFF;
      dp     <= DP_OFF;
      an     <= AN_OFF;
    end else begin
      a_to_g <= segNext;
      dp     <= dpNext;
      an     <= anNext;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: 4 digits, 4-cycle slots, 1 blank cycle.
// A second instance with BCD decode shares all inputs.
module tb_sevenseg_scan;

  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      dpIn;
    logic [3:0]      blankIn;
    logic            lzEn;
    logic [3:0][6:0] segs;
    logic [3:0]      dpExp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dpIn = '0;
  logic [3:0]  blankIn = '0;
  logic        lzEn = 1'b0;
  logic        load = 1'b0;
  logic        enable = 1'b1;
  logic [6:0]  aToG, segHex0;
  logic        dp, dpHex0;
  logic [3:0]  an, anHex0;
  logic        frameDone, fdHex0;

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[9];

  sevenseg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1),
                  .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dpIn), .blank_in(blankIn),
    .lz_en(lzEn), .load(load), .enable(enable), .a_to_g(aToG), .dp(dp), .an(an),
    .frame_done(frameDone));

  sevenseg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0),
                  .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dutBcd (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dpIn), .blank_in(blankIn),
    .lz_en(lzEn), .load(load), .enable(enable), .a_to_g(segHex0), .dp(dpHex0), .an(anHex0),
    .frame_done(fdHex0));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Loads the shadow with a single-cycle strobe, then leaves load low.
  task automatic loadShadow(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic lz);
    @(negedge clk);
    digits = d; dpIn = p; blankIn = b; lzEn = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge where frame_done is high (bounded).
  task automatic waitFrame();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (frameDone) seen = 1'b1;
    end
    if (!seen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL frame_wait: got no frame_done expected pulse within 40 cycles");
    end
  endtask

  // Load one vector and check every digit slot of the following frame.
  task automatic applyStimulus(input int n, input vec_t v);
    logic [6:0] expBcd;
    loadShadow(v.digits, v.dpIn, v.blankIn, v.lzEn);
    waitFrame();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      expBcd = (v.digits[4*k +: 4] > 4'd9) ? 7'h7F : v.segs[k];
      checkOutput($sformatf("v%0d_d%0d_an", n, k), {12'd0, an}, {12'd0, ~(4'b0001 << k)});
      checkOutput($sformatf("v%0d_d%0d_seg", n, k), {9'd0, aToG}, {9'd0, v.segs[k]});
      checkOutput($sformatf("v%0d_d%0d_dp", n, k), {15'd0, dp}, {15'd0, v.dpExp[k]});
      checkOutput($sformatf("v%0d_d%0d_anbcd", n, k), {12'd0, anHex0}, {12'd0, ~(4'b0001 << k)});
      checkOutput($sformatf("v%0d_d%0d_segbcd", n, k), {9'd0, segHex0}, {9'd0, expBcd});
      if (k < 3) repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1A3F, 4'b0100, 4'b0000, 1'b0,
                {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 4'b1011};
    vecs[1] = '{16'h0070, 4'b1000, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0001111, 7'b0000001}, 4'b0111};
    vecs[2] = '{16'h8888, 4'b0011, 4'b0010, 1'b0,
                {7'b0000000, 7'b0000000, 7'b1111111, 7'b0000000}, 4'b1110};
    vecs[3] = '{16'h0000, 4'b0001, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1110};
    vecs[4] = '{16'hBCDE, 4'b0000, 4'b0000, 1'b1,
                {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b1111};
    vecs[5] = '{16'h9876, 4'b0000, 4'b0000, 1'b0,
                {7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000}, 4'b1111};
    vecs[6] = '{16'h0524, 4'b0000, 4'b0000, 1'b1,
                {7'b1111111, 7'b0100100, 7'b0010010, 7'b1001100}, 4'b1111};
    vecs[7] = '{16'h0100, 4'b0010, 4'b0000, 1'b1,
                {7'b1111111, 7'b1001111, 7'b0000001, 7'b0000001}, 4'b1101};
    vecs[8] = '{16'h00C0, 4'b0000, 4'b0000, 1'b0,
                {7'b0000001, 7'b0000001, 7'b0110001, 7'b0000001}, 4'b1111};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_an", {12'd0, an}, 16'h000F);
    checkOutput("rst_seg", {9'd0, aToG}, 16'h007F);
    checkOutput("rst_dp", {15'd0, dp}, 16'h0001);
    checkOutput("rst_fd", {15'd0, frameDone}, 16'h0000);
    checkOutput("rst_fdbcd", {15'd0, fdHex0}, 16'h0000);
    checkOutput("rst_dpbcd", {15'd0, dpHex0}, 16'h0001);

    // Free-running scan after release: reference model of slot position.
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      int s, p, i;
      @(negedge clk);
      s = k - 1; p = s % 4; i = (s / 4) % 4;
      checkOutput($sformatf("scan%0d_an", k), {12'd0, an},
                  (p < 1) ? 16'h000F : {12'd0, ~(4'b0001 << i)});
      checkOutput($sformatf("scan%0d_seg", k), {9'd0, aToG}, 16'h0001);
      checkOutput($sformatf("scan%0d_fd", k), {15'd0, frameDone}, {15'd0, (k % 16) == 0});
    end

    foreach (vecs[n]) applyStimulus(n, vecs[n]);

    // Mid-slot load at prescaler 2 of digit 1, then a load on a slot-start cycle.
    loadShadow(16'h1111, 4'b0000, 4'b0000, 1'b0);
    waitFrame();
    repeat (6) @(negedge clk);
    digits = 16'h2222; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checkOutput("midload_m7_seg", {9'd0, aToG}, 16'h004F);
    @(negedge clk);
    checkOutput("midload_m8_an", {12'd0, an}, 16'h000D);
    checkOutput("midload_m8_seg", {9'd0, aToG}, 16'h004F);
    digits = 16'h3333; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checkOutput("slotload_m10_an", {12'd0, an}, 16'h000B);
    checkOutput("slotload_m10_seg", {9'd0, aToG}, 16'h0012);
    repeat (4) @(negedge clk);
    checkOutput("slotload_m14_an", {12'd0, an}, 16'h0007);
    checkOutput("slotload_m14_seg", {9'd0, aToG}, 16'h0006);
    repeat (8) @(negedge clk);
    checkOutput("nextframe_m22_an", {12'd0, an}, 16'h000D);
    checkOutput("nextframe_m22_seg", {9'd0, aToG}, 16'h0006);

    // Enable drop and re-raise without counter restart.
    waitFrame();
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("dis_an", {12'd0, an}, 16'h000F);
    checkOutput("dis_seg", {9'd0, aToG}, 16'h007F);
    checkOutput("dis_dp", {15'd0, dp}, 16'h0001);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("reen_an", {12'd0, an}, 16'h000B);
    checkOutput("reen_seg", {9'd0, aToG}, 16'h0006);
    repeat (6) @(negedge clk);
    checkOutput("reen_fd", {15'd0, frameDone}, 16'h0001);

    // Asynchronous reset mid-slot.
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_an", {12'd0, an}, 16'h000F);
    checkOutput("arst_seg", {9'd0, aToG}, 16'h007F);
    checkOutput("arst_dp", {15'd0, dp}, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart1_an", {12'd0, an}, 16'h000F);
    checkOutput("restart1_seg", {9'd0, aToG}, 16'h0001);
    @(negedge clk);
    checkOutput("restart2_an", {12'd0, an}, 16'h000E);
    checkOutput("restart2_seg", {9'd0, aToG}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display.
- Replaces per-digit combinational decoding: holds a shadow copy of the digit values and scans one digit per slot.
- Decodes hex or BCD, suppresses leading zeros, and drives decimal points.
- Applies an anti-ghosting blank interval at the start of every slot.
- Sits between the distance/measurement logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits (>=1); digit 0 is least significant/rightmost.
- SCAN_DIV, 50000, clock cycles per digit slot (>=2).
- BLANK_CYCLES, 500, cycles at slot start with all anodes off (0 <= BLANK_CYCLES < SCAN_DIV).
- HEX_MODE, 1, 1: codes 10-15 render A,b,C,d,E,F; 0: codes 10-15 render blank.
- SEG_ACTIVE_LOW, 1, 1: segment/dp lit when 0.
- AN_ACTIVE_LOW, 1, 1: anode enabled when 0.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- digits, input, 4*NUM_DIGITS, packed nibbles; digit i = digits[4i+3:4i].
- dp_in, input, NUM_DIGITS, decimal point request per digit.
- blank_in, input, NUM_DIGITS, force digit i dark (dp included).
- lz_en, input, 1, leading-zero suppression enable.
- load, input, 1, single-cycle strobe; captures digits/dp_in/blank_in into shadow.
- enable, input, 1, 0 = display dark; counters keep running.
- a_to_g, output, 7, segments, bit 6 = a … bit 0 = g; registered.
- dp, output, 1, decimal point; registered.
- an, output, NUM_DIGITS, anode selects, one-hot when active; registered.
- frame_done, output, 1, one-cycle pulse at end of each full scan.

Behaviour:
- Reset (async assert, sync to clk on release):
  - prescaler=0, idx=0, shadow=0.
  - a_to_g=all off, dp=off, an=all off, frame_done=0.
  - "Off" means 1 when the corresponding ACTIVE_LOW parameter is 1.
- Counters:
  - prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx increments; idx wraps NUM_DIGITS-1 -> 0.
  - frame_done=1 for exactly one cycle, on the cycle after idx wraps to 0.
  - NUM_DIGITS=1: idx stays 0 and frame_done pulses every SCAN_DIV cycles.
- Shadow: on a load edge, digits/dp_in/blank_in are captured. Without load, the shadow holds.
- Slot latch: when prescaler==0, the current digit's code, dp and blank are latched from the shadow. A load mid-slot therefore never changes the digit being displayed; it takes effect from the next slot.
- Leading-zero suppression, computed from the shadow when lz_en=1:
  - Digit i is suppressed if digits j>=i are all zero and i>0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows its dp if requested.
- Decode, abcdefg in active-low form (invert all when SEG_ACTIVE_LOW=0):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Blank=1111111.
- Outputs, registered one cycle after the prescaler/idx state they reflect:
  - an is one-hot on idx when enable=1 and prescaler >= BLANK_CYCLES; otherwise all off.
  - a_to_g/dp show the latched digit, or blank if blank_in or suppressed.
  - With enable=0, segments, dp and an are all off.
- Simultaneous events: a load on a prescaler==0 cycle is not seen by that slot latch; the slot uses the old shadow.
- Reset mid-slot: outputs go dark immediately (asynchronous) and the scan restarts at digit 0.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, HEX_MODE=1, both ACTIVE_LOW=1):
- Reset, then release rst_n with enable=1 and no load:
  - an=1111 for the first slot's blank cycle, then 1110.
  - a_to_g=0000001; idx advances every 4 cycles.
  - frame_done pulses every 16 cycles.
- Load digits=16'h1A3F, dp_in=4'b0100, lz_en=0 -> across one frame:
  - an 1110 shows 0111000 (F).
  - an 1101 shows 0000110 (3).
  - an 1011 shows 0001000 (A) with dp=0.
  - an 0111 shows 1001111 (1).
- Load digits=16'h0070, lz_en=1, dp_in=4'b1000:
  - Digit 0 shows 0000001.
  - Digit 1 shows 0001111.
  - Digits 2 and 3 show 1111111, with digit 3 dp=0.
- With HEX_MODE=0, load digits=16'h00C0 -> digit 1 shows 1111111.
- Pulse load with new digits at prescaler==2 of the digit-1 slot -> that slot's segments do not change; the digit-1 slot of the next frame shows the new value.
- Drop enable mid-slot -> one cycle later, an=1111 and a_to_g=1111111. Re-raise enable -> display resumes with no counter restart. Assert rst_n=0 mid-slot -> outputs dark immediately, and the scan restarts at idx=0.
